// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stalls IF/ID and bubbles EX for non-forwardable hazards; owns the mult/div busy sequencer.
// Optional macro HAZARD_STATS_EN adds saturating stall_cycles/md_stall_cycles counters.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic [4:0] WriteReg_EX,
    input  logic [4:0] WriteReg_MEM,
    input  logic       regWr_EX,
    input  logic       memToReg_EX,
    input  logic       memToReg_MEM,
    input  logic       branch_ID,
    input  logic       jr_ID,
    input  logic       md_use_ID,
    input  logic       md_start_EX,
    input  logic       md_is_div_EX,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       md_busy,
`ifdef HAZARD_STATS_EN
    output logic       md_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] md_stall_cycles
`else
    output logic       md_done
`endif
);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic             ex_rs, ex_rt, mem_rs, mem_rt;
    logic             lwstall, brstall, jrstall, mdstall, stall;

    // $0 is hardwired zero, so a write to it never creates a dependence
    assign ex_rs  = regWr_EX & (WriteReg_EX != 5'd0) & (WriteReg_EX == rs_ID);
    assign ex_rt  = regWr_EX & (WriteReg_EX != 5'd0) & (WriteReg_EX == rt_ID);
    assign mem_rs = memToReg_MEM & (WriteReg_MEM != 5'd0) & (WriteReg_MEM == rs_ID);
    assign mem_rt = memToReg_MEM & (WriteReg_MEM != 5'd0) & (WriteReg_MEM == rt_ID);

    assign lwstall = memToReg_EX & (ex_rs | ex_rt);
    assign brstall = branch_ID & (ex_rs | ex_rt | mem_rs | mem_rt);
    assign jrstall = jr_ID & (ex_rs | mem_rs);
    assign mdstall = md_use_ID & (busy_q | md_start_EX);
    assign stall   = ~rst & (lwstall | brstall | jrstall | mdstall);

    assign StallF  = stall;
    assign StallD  = stall;
    assign FlushE  = stall;
    assign md_busy = busy_q;
    assign md_done = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            done_q <= 1'b0;
            if (md_start_EX) begin
                state_q <= BUSY;
                cnt_q   <= md_is_div_EX ? DIV_LOAD : MULT_LOAD;
                busy_q  <= 1'b1;
            end
        end else if (cnt_q > CNT_W'(1)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, md_stall_cycles_q;

    assign stall_cycles    = stall_cycles_q;
    assign md_stall_cycles = md_stall_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q    <= '0;
            md_stall_cycles_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_q + {31'd0, stall & ~&stall_cycles_q};
            md_stall_cycles_q <= md_stall_cycles_q + {31'd0, mdstall & ~&md_stall_cycles_q};
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random stimulus against a cycle-indexed reference model, checked via scoreboard queue.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, we, wm;
    logic       regE, memE, memM, br, jr, use_md, start, isdiv;
    logic       sf, sd, fe, busy, done;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc, msc;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rs_ID(rs), .rt_ID(rt), .WriteReg_EX(we), .WriteReg_MEM(wm),
        .regWr_EX(regE), .memToReg_EX(memE), .memToReg_MEM(memM),
        .branch_ID(br), .jr_ID(jr), .md_use_ID(use_md),
        .md_start_EX(start), .md_is_div_EX(isdiv),
        .StallF(sf), .StallD(sd), .FlushE(fe),
        .md_busy(busy),
`ifdef HAZARD_STATS_EN
        .md_done(done), .stall_cycles(sc), .md_stall_cycles(msc)
`else
        .md_done(done)
`endif
    );

    typedef struct {
        logic [4:0]  o;
        logic [31:0] sc;
        logic [31:0] msc;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0;
    int          cyc = 0, st = 0, n = 0;
    bit          active = 0;
    logic [31:0] m_sc = 0, m_msc = 0;

    // A register is "not yet available" if the EX writer or the MEM load targets it
    function automatic bit hit(input logic [4:0] r);
        return (regE && we != 0 && we == r) || (memM && wm != 0 && wm == r);
    endfunction

    task automatic clr();
        rs = 0; rt = 0; we = 0; wm = 0;
        regE = 0; memE = 0; memM = 0; br = 0; jr = 0;
        use_md = 0; start = 0; isdiv = 0;
    endtask

    task automatic step();
        exp_t e;
        bit b, d, lw, brs, jrs, mds, s;
        if (rst) begin
            active = 0;
            m_sc = 0;
            m_msc = 0;
        end
        b   = active && cyc > st && cyc < st + n;
        d   = active && cyc == st + n;
        lw  = memE && regE && we != 0 && (we == rs || we == rt);
        brs = br && (hit(rs) || hit(rt));
        jrs = jr && hit(rs);
        mds = use_md && (b || start);
        s   = !rst && (lw || brs || jrs || mds);
        e.o = {s, s, s, b, d};
        e.sc = m_sc;
        e.msc = m_msc;
        e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (start && !b) begin
                active = 1;
                st = cyc;
                n = isdiv ? 10 : 5;
            end
            if (s && m_sc != 32'hFFFFFFFF) m_sc++;
            if (mds && m_msc != 32'hFFFFFFFF) m_msc++;
        end
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if ({sf, sd, fe, busy, done} !== e.o) begin
                fails++;
                $display("FAIL ctl cyc %0d: got {StallF,StallD,FlushE,busy,done}=%b want %b", e.cyc, {sf, sd, fe, busy, done}, e.o);
            end
`ifdef HAZARD_STATS_EN
            tests++;
            if (sc !== e.sc || msc !== e.msc) begin
                fails++;
                $display("FAIL stats cyc %0d: got %0d/%0d want %0d/%0d", e.cyc, sc, msc, e.sc, e.msc);
            end
`endif
        end
    end

    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        step(); step();
        rst = 0;
        // load-use
        memE = 1; regE = 1; we = 8; rs = 8; step();
        rs = 9; rt = 10; step();
        rs = 8; we = 0; step();
        // branch and jr
        clr(); br = 1; rt = 5; regE = 1; we = 5; step();
        regE = 0; memM = 1; wm = 5; step();
        memM = 0; step();
        clr(); jr = 1; rt = 5; regE = 1; we = 5; step();
        regE = 0; memM = 1; wm = 5; step();
        rs = 5; step();
        // mult with md_use held
        clr(); use_md = 1; start = 1; isdiv = 0; step();
        start = 0; repeat (6) step();
        // div then mult started on the done cycle
        clr(); start = 1; isdiv = 1; step();
        start = 0; repeat (9) step();
        start = 1; isdiv = 0; step();
        start = 0; repeat (6) step();
        // async reset mid-div
        clr(); start = 1; isdiv = 1; step();
        start = 0; use_md = 1; repeat (3) step();
        rst = 1; step();
        rst = 0; repeat (12) step();
        // stall counter scenario
        clr(); memE = 1; regE = 1; we = 3; rs = 3; repeat (3) step();
        clr(); use_md = 1; start = 1; step();
        start = 0; step();
        clr(); repeat (5) step();
        // random
        repeat (3000) begin
            rst   = ($urandom_range(0, 199) == 0);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            we    = 5'($urandom_range(0, 3));
            wm    = 5'($urandom_range(0, 3));
            regE  = 1'($urandom);
            memE  = 1'($urandom);
            memM  = 1'($urandom);
            br    = ($urandom_range(0, 3) == 0);
            jr    = ($urandom_range(0, 3) == 0);
            use_md = 1'($urandom);
            start = ($urandom_range(0, 7) == 0);
            isdiv = 1'($urandom);
            step();
        end
        rst = 0;
        clr();
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; the stall/flush counterpart to the forwarding unit.
- The forwarding unit resolves hazards that a bypass can fix; this block stalls IF/ID and bubbles EX for hazards that a bypass cannot fix:
  - load-use
  - branch/jr compare in ID against a not-yet-available result
  - instructions that read HI/LO while the multi-cycle mult/div unit is busy
- Owns the mult/div busy sequencer (cycle counter plus FSM).

Parameters:
- MULT_CYCLES, 5, EX-to-result latency of mult/multu in cycles (>=2)
- DIV_CYCLES, 10, latency of div/divu in cycles (>=2, >=MULT_CYCLES)
- CNT_W, 5, width of the busy down-counter; must hold DIV_CYCLES

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rs_ID  in  5  rs field of the instruction in ID
- rt_ID  in  5  rt field of the instruction in ID
- WriteReg_EX  in  5  destination register of the instruction in EX
- WriteReg_MEM  in  5  destination register of the instruction in MEM
- regWr_EX  in  1  EX instruction writes the register file
- memToReg_EX  in  1  EX instruction is a load
- memToReg_MEM  in  1  MEM instruction is a load
- branch_ID  in  1  ID instruction is beq/bne (compares rs and rt in ID)
- jr_ID  in  1  ID instruction is jr/jalr (reads rs in ID)
- md_use_ID  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- md_start_EX  in  1  mult/div issued in EX this cycle
- md_is_div_EX  in  1  qualifies md_start_EX: 1=div, 0=mult
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushE  out  1  clear ID/EX register (insert bubble)
- md_busy  out  1  mult/div unit computing
- md_done  out  1  one-cycle pulse: HI/LO valid this cycle

Behaviour:
- Reset (async, rst=1):
  - md_busy=0, md_done=0, counter=0, FSM=IDLE.
  - StallF/StallD/FlushE forced 0 while rst=1, regardless of inputs.
- Hazard terms, combinational, same cycle as inputs. Register $0 never causes a stall.
  - lwstall = memToReg_EX & regWr_EX & WriteReg_EX!=0 & (WriteReg_EX==rs_ID | WriteReg_EX==rt_ID).
  - brstall = branch_ID & [ (regWr_EX & WriteReg_EX!=0 & WriteReg_EX∈{rs_ID,rt_ID}) | (memToReg_MEM & WriteReg_MEM!=0 & WriteReg_MEM∈{rs_ID,rt_ID}) ].
  - jrstall: same as brstall, but gated by jr_ID and matching rs_ID only.
  - mdstall = md_use_ID & (md_busy | md_start_EX).
  - stall = lwstall | brstall | jrstall | mdstall.
  - StallF = StallD = FlushE = stall.
- Mult/div FSM, states IDLE and BUSY:
  - IDLE, md_start_EX=1: next state BUSY; counter <= (md_is_div_EX ? DIV_CYCLES : MULT_CYCLES) - 1; md_busy=1 from the next cycle.
  - BUSY, counter>1: counter decrements by 1.
  - BUSY, counter==1: next state IDLE; counter <= 0; md_done=1 for exactly the following cycle; md_busy drops in that same cycle.
  - Total: md_busy high for N-1 cycles, then md_done pulses, so the result is available N cycles after the start cycle.
  - md_start_EX while BUSY: ignored, no restart. It cannot legally occur because mdstall blocks the issue.
  - md_start_EX in the same cycle md_done is high: accepted (FSM is IDLE).
- md_done is registered and never asserted together with md_busy.
- rst mid-BUSY: counter cleared, FSM to IDLE, no md_done pulse.
- Counter arithmetic is unsigned CNT_W bits and never underflows (decrement only when >1).

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and md_stall_cycles[31:0], both reset to 0 by rst.
  - stall_cycles increments each cycle stall=1.
  - md_stall_cycles increments each cycle mdstall=1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Load-use: memToReg_EX=1, regWr_EX=1, WriteReg_EX=8, rs_ID=8 -> StallF=StallD=FlushE=1 same cycle. Change rs_ID=9, rt_ID=10 -> all 0. Set WriteReg_EX=0 -> all 0.
- Branch: branch_ID=1, rt_ID=5, regWr_EX=1, WriteReg_EX=5 -> stall=1. Next: regWr_EX=0, memToReg_MEM=1, WriteReg_MEM=5 -> stall=1. Next: memToReg_MEM=0 -> stall=0. Repeat with jr_ID=1 and rt match only -> stall=0.
- Mult: pulse md_start_EX=1, md_is_div_EX=0 at cycle 0 -> md_busy=1 cycles 1-4, md_done=1 cycle 5 only, md_busy=0 from cycle 5. md_use_ID=1 held throughout -> stall=1 cycles 0-4, 0 at cycle 5.
- Div back-to-back: div start at cycle 0 -> md_done at cycle 10. New mult start at cycle 10 -> md_busy cycles 11-14, md_done at cycle 15.
- Reset mid-op: start div, assert rst at cycle 4 asynchronously (between edges) -> md_busy=0 immediately, StallF=0, no md_done pulse after release.
- HAZARD_STATS_EN: 3 load-use stall cycles plus 2 md stall cycles -> stall_cycles=5, md_stall_cycles=2. rst -> both 0.
